// File: rtl/pio_input_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pio_input_pkg
// Brief    : Register map and bus width shared by the debounced input PIO.
// Revision : 1.0 - initial release
// ============================================================================
package pio_input_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd1;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd2;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/input_debounce_cell.sv
`default_nettype none
// ============================================================================
// Module   : input_debounce_cell
// Brief    : One input channel: synchronizer, tick-based debounce, edge pulses.
// Revision : 1.0 - initial release
// ============================================================================
module input_debounce_cell
    import pio_input_pkg::*;
#(
    parameter int   SYNC_STAGES  = 2,
    parameter int   STABLE_TICKS = 10,
    parameter logic RESET_BIT    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_in,
    input  logic tick,
    output logic deb,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W   = $clog2(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_TICKS);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   deb_q, deb_d;
    logic                   deb_prev_q, deb_prev_d;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], pin_in};
        cnt_inc    = cnt_q + CNT_W'(1);
        cnt_d      = cnt_q;
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        // Any cycle where the synchronized input agrees with deb restarts the count
        if (sync_q[SYNC_STAGES-1] == deb_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_inc == CNT_MAX) begin
                deb_d = ~deb_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= {SYNC_STAGES{RESET_BIT}};
            cnt_q      <= '0;
            deb_q      <= RESET_BIT;
            deb_prev_q <= RESET_BIT;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
        end
    end

    assign deb  = deb_q;
    assign rise = deb_q & ~deb_prev_q;
    assign fall = ~deb_q & deb_prev_q;

endmodule
`default_nettype wire

// File: rtl/pio_input_debounced.sv
`default_nettype none
// ============================================================================
// Module   : pio_input_debounced
// Brief    : Avalon-MM input PIO with per-channel debounce, edge capture, IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module pio_input_debounced
    import pio_input_pkg::*;
#(
    parameter int               WIDTH        = 10,
    parameter int               SYNC_STAGES  = 2,
    parameter int               TICK_CYCLES  = 50000,
    parameter int               STABLE_TICKS = 10,
    parameter logic [WIDTH-1:0] RESET_LEVEL  = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  pin_in,
    input  logic [2:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              irq
);

    localparam int               PRE_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_CYCLES - 1);

    logic [PRE_W-1:0]  presc_q, presc_d;
    logic              tick;
    logic [WIDTH-1:0]  deb, rise, fall;
    logic [WIDTH-1:0]  irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0]  edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0]  rise_en_q, rise_en_d;
    logic [WIDTH-1:0]  fall_en_q, fall_en_d;
    logic [WIDTH-1:0]  wdata, w1c, cap_set;
    logic [DATA_W-1:0] readdata_q, readdata_d, rd_word;
    logic              unused_writedata;

    assign unused_writedata = ^writedata;

    assign tick    = (presc_q == PRE_MAX);
    assign presc_d = tick ? '0 : presc_q + PRE_W'(1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        input_debounce_cell #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS),
            .RESET_BIT    (RESET_LEVEL[i])
        ) u_cell (
            .clk    (clk),
            .reset  (reset),
            .pin_in (pin_in[i]),
            .tick   (tick),
            .deb    (deb[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    always_comb begin
        wdata      = writedata[WIDTH-1:0];
        w1c        = '0;
        irq_mask_d = irq_mask_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        if (write) begin
            case (address)
                ADDR_IRQ_MASK: irq_mask_d = wdata;
                ADDR_EDGE_CAP: w1c        = wdata;
                ADDR_RISE_EN:  rise_en_d  = wdata;
                ADDR_FALL_EN:  fall_en_d  = wdata;
                default: ;
            endcase
        end
        // Set term is OR'd after the clear so a new edge survives a racing W1C
        cap_set    = (rise & rise_en_q) | (fall & fall_en_q);
        edge_cap_d = (edge_cap_q & ~w1c) | cap_set;

        rd_word = '0;
        case (address)
            ADDR_DATA:     rd_word[WIDTH-1:0] = deb;
            ADDR_IRQ_MASK: rd_word[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGE_CAP: rd_word[WIDTH-1:0] = edge_cap_q;
            ADDR_RISE_EN:  rd_word[WIDTH-1:0] = rise_en_q;
            ADDR_FALL_EN:  rd_word[WIDTH-1:0] = fall_en_q;
            default: ;
        endcase
        readdata_d = readdata_q;
        if (read && !write) begin
            readdata_d = rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q    <= '0;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            rise_en_q  <= '1;
            fall_en_q  <= '0;
            readdata_q <= '0;
        end else begin
            presc_q    <= presc_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_cap_q & irq_mask_q);

endmodule
`default_nettype wire

// File: tb/tb_pio_input_debounced.sv
`default_nettype none
// ============================================================================
// Module   : tb_pio_input_debounced
// Brief    : Directed self-checking bench for pio_input_debounced.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pio_input_debounced;

    localparam int         WIDTH        = 4;
    localparam int         SYNC_STAGES  = 2;
    localparam int         TICK_CYCLES  = 4;
    localparam int         STABLE_TICKS = 3;
    localparam logic [3:0] RESET_LEVEL  = 4'b0011;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  pin_in;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pio_input_debounced #(
        .WIDTH        (WIDTH),
        .SYNC_STAGES  (SYNC_STAGES),
        .TICK_CYCLES  (TICK_CYCLES),
        .STABLE_TICKS (STABLE_TICKS),
        .RESET_LEVEL  (RESET_LEVEL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pin_in    (pin_in),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        step(1);
        write     = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b1;
        step(1);
        read    = 1'b0;
        d       = readdata;
    endtask

    task automatic align_phase();
        while (cyc % TICK_CYCLES != 0) step(1);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset = 1'b1; pin_in = 4'b0011; read = 1'b0; write = 1'b0;
        address = 3'd0; writedata = 32'd0;
        step(3);
        n_checks++;
        if (readdata !== 32'd0) begin n_fail++; $display("FAIL reset_readdata: got %0h expected 0", readdata); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
        reset = 1'b0;
        for (int n = 0; n < 100; n++) begin
            step(1);
            n_checks++;
            if (irq !== 1'b0) begin n_fail++; $display("FAIL idle_irq cycle %0d: got %b expected 0", n, irq); end
        end
        bus_read(3'd0, rd);
        n_checks++;
        if (rd !== 32'h3) begin n_fail++; $display("FAIL reset_data: got %0h expected 3", rd); end
        bus_read(3'd2, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_edge_cap: got %0h expected 0", rd); end
        bus_read(3'd1, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_irq_mask: got %0h expected 0", rd); end
        bus_read(3'd3, rd);
        n_checks++;
        if (rd !== 32'hF) begin n_fail++; $display("FAIL reset_rise_en: got %0h expected f", rd); end
        bus_read(3'd4, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_fall_en: got %0h expected 0", rd); end
    endtask

    task automatic test_rise();
        logic [31:0] rd;
        int first;
        bus_write(3'd1, 32'h4);
        pin_in[2] = 1'b1;
        first = 0;
        for (int n = 1; n <= 20 && first == 0; n++) begin
            step(1);
            if (irq === 1'b1) first = n;
        end
        // 2 sync cycles + 3 ticks of 4 cycles (phase dependent) + 1 capture cycle
        n_checks++;
        if (first < 12 || first > 15) begin n_fail++; $display("FAIL rise_irq_latency: got %0d expected 12..15", first); end
        bus_read(3'd0, rd);
        n_checks++;
        if (rd !== 32'h7) begin n_fail++; $display("FAIL rise_data: got %0h expected 7", rd); end
        bus_read(3'd2, rd);
        n_checks++;
        if (rd !== 32'h4) begin n_fail++; $display("FAIL rise_edge_cap: got %0h expected 4", rd); end
        bus_write(3'd2, 32'h4);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL rise_irq_clear: got %b expected 0", irq); end
    endtask

    task automatic test_glitch();
        logic [31:0] rd;
        for (int n = 0; n < 200; n++) begin
            pin_in[3] = (n % 3 == 0);
            step(1);
            n_checks++;
            if (irq !== 1'b0) begin n_fail++; $display("FAIL glitch_irq cycle %0d: got %b expected 0", n, irq); end
        end
        pin_in[3] = 1'b0;
        step(10);
        bus_read(3'd0, rd);
        n_checks++;
        if (rd !== 32'h7) begin n_fail++; $display("FAIL glitch_data: got %0h expected 7", rd); end
        bus_read(3'd2, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL glitch_edge_cap: got %0h expected 0", rd); end
    endtask

    task automatic test_fall();
        logic [31:0] rd;
        bus_write(3'd4, 32'h1);
        bus_write(3'd3, 32'h0);
        pin_in[0] = 1'b0;
        step(20);
        bus_read(3'd0, rd);
        n_checks++;
        if (rd !== 32'h6) begin n_fail++; $display("FAIL fall_data: got %0h expected 6", rd); end
        bus_read(3'd2, rd);
        n_checks++;
        if (rd !== 32'h1) begin n_fail++; $display("FAIL fall_edge_cap: got %0h expected 1", rd); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL fall_irq_masked: got %b expected 0", irq); end
        pin_in[0] = 1'b1;
        step(20);
        bus_read(3'd0, rd);
        n_checks++;
        if (rd !== 32'h7) begin n_fail++; $display("FAIL fall_rerise_data: got %0h expected 7", rd); end
        bus_read(3'd2, rd);
        n_checks++;
        if (rd !== 32'h1) begin n_fail++; $display("FAIL fall_rerise_edge_cap: got %0h expected 1", rd); end
        bus_write(3'd2, 32'h0);
        bus_read(3'd2, rd);
        n_checks++;
        if (rd !== 32'h1) begin n_fail++; $display("FAIL w0_no_effect: got %0h expected 1", rd); end
        bus_write(3'd2, 32'h1);
        bus_read(3'd2, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL fall_w1c: got %0h expected 0", rd); end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] rd;
        int first;
        bus_write(3'd3, 32'h4);
        bus_write(3'd4, 32'h0);
        pin_in[2] = 1'b0;
        step(20);
        bus_read(3'd0, rd);
        n_checks++;
        if (rd !== 32'h3) begin n_fail++; $display("FAIL coll_drop_data: got %0h expected 3", rd); end
        bus_read(3'd2, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL coll_drop_edge_cap: got %0h expected 0", rd); end
        // Measure capture latency at a known prescaler phase, then replay it
        align_phase();
        pin_in[2] = 1'b1;
        first = 0;
        for (int n = 1; n <= 20 && first == 0; n++) begin
            step(1);
            if (irq === 1'b1) first = n;
        end
        n_checks++;
        if (first < 12 || first > 15) begin n_fail++; $display("FAIL coll_probe_latency: got %0d expected 12..15", first); end
        if (first == 0) first = 13;
        bus_write(3'd2, 32'h4);
        pin_in[2] = 1'b0;
        step(20);
        align_phase();
        pin_in[2] = 1'b1;
        step(first - 1);
        bus_write(3'd2, 32'h4);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL coll_irq: got %b expected 1", irq); end
        bus_read(3'd2, rd);
        n_checks++;
        if (rd !== 32'h4) begin n_fail++; $display("FAIL coll_edge_cap: got %0h expected 4", rd); end
        bus_write(3'd2, 32'h4);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL coll_clear_irq: got %b expected 0", irq); end
    endtask

    task automatic test_addr_map();
        logic [31:0] rd;
        for (int a = 5; a < 8; a++) begin
            bus_write(3'(a), 32'hFFFF_FFFF);
            bus_read(3'(a), rd);
            n_checks++;
            if (rd !== 32'h0) begin n_fail++; $display("FAIL unused_addr_%0d: got %0h expected 0", a, rd); end
        end
        bus_write(3'd1, 32'hFFFF_FFFF);
        bus_read(3'd1, rd);
        n_checks++;
        if (rd !== 32'hF) begin n_fail++; $display("FAIL irq_mask_readback: got %0h expected f", rd); end
        address = 3'd0;
        step(5);
        n_checks++;
        if (readdata !== 32'hF) begin n_fail++; $display("FAIL readdata_hold: got %0h expected f", readdata); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL full_mask_irq: got %b expected 0", irq); end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_glitch();
        test_fall();
        test_w1c_collision();
        test_addr_map();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
